// File: rtl/addrc_controller.sv
// addrc_controller: round/slice sequencer for the ADDRC datapath (64 slices, 24 rounds).
// Define ADDRC_CTRL_PIPE_EN to stream one slice per cycle while in OUT.
module addrc_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] roundIn,
    input  logic       inValid,
    input  logic       outReady,
    input  logic       sliceCntCo,
    output logic       ready,
    output logic       inReady,
    output logic       outValid,
    output logic       done,
    output logic       err,
    output logic [4:0] cycleNum,
    output logic       sliceCntEn,
    output logic       sliceCntClr,
    output logic       ldReg,
    output logic       clrReg
);
    typedef enum logic [2:0] {IDLE, INIT, WAIT_IN, OUT, DONE} stateT;
    stateT state, nxt;
    logic inReadyQ, startOk, stream;
    always_comb startOk = start && (roundIn < 5'd24);
`ifdef ADDRC_CTRL_PIPE_EN
    always_comb stream = (state == OUT) && outReady && inValid && !sliceCntCo;
`else
    always_comb stream = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = startOk ? INIT : IDLE;
            INIT:    nxt = WAIT_IN;
            WAIT_IN: nxt = inValid ? OUT : WAIT_IN;
            OUT:     nxt = (!outReady || stream) ? OUT : (sliceCntCo ? DONE : WAIT_IN);
            default: nxt = IDLE;
        endcase
    end
    // Handshake-dependent controls are Mealy; everything else is registered from nxt
    always_comb begin
        ldReg      = ((state == WAIT_IN) && inValid) || stream;
        sliceCntEn = (state == OUT) && outReady;
        inReady    = inReadyQ || stream;
        err        = (state == IDLE) && start && !startOk;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cycleNum    <= 5'd0;
            ready       <= 1'b1;
            inReadyQ    <= 1'b0;
            outValid    <= 1'b0;
            sliceCntClr <= 1'b0;
            clrReg      <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= nxt;
            cycleNum    <= (state == IDLE && startOk) ? roundIn : cycleNum;
            ready       <= nxt == IDLE;
            inReadyQ    <= nxt == WAIT_IN;
            outValid    <= nxt == OUT;
            sliceCntClr <= nxt == INIT;
            clrReg      <= nxt == INIT;
            done        <= nxt == DONE;
        end
    end
endmodule
